// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and state encodings shared by the sequential ALU and its multiplier.
// Revision: 1.0
`default_nettype none

package seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Two's-complement overflow from the operand and result sign bits.
   function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr,
                                       input logic is_sub);
      if (is_sub) return (sa != sb) && (sr != sa);
      return (sa == sb) && (sr != sa);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_mul_iter.sv
// seq_alu_mul_iter: iterative shift-add multiplier, one multiplier bit per clock, LSB first.
// Revision: 1.0
`default_nettype none

module seq_alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;

   // The final partial sum is presented combinationally so the caller can register it
   // on the same edge that consumes the last multiplier bit.
   assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign product = acc_d;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         acc_q    <= '0;
         mplier_q <= b;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake; single-cycle logic ops and an
// optional iterative multiply that stalls the input side while it runs. Revision: 1.0
`default_nettype none

module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit MUL_ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] rdDataA,
   input  logic [WIDTH-1:0] rdDataB,
   input  logic [2:0]       opSelect,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] outData,
   output logic             flagZ,
   output logic             flagN,
   output logic             flagC,
   output logic             flagV,
   output logic             errIllegal
);
   localparam int SHW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
   logic               accept, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH:0]     ext;
   logic               alu_c, alu_v, alu_err;
   op_e                op;

   assign op         = op_e'(opSelect);
   assign inReady    = (state_q == S_IDLE) || ((state_q == S_DONE) && outReady);
   assign accept     = inValid && inReady;
   assign outValid   = (state_q == S_DONE);
   assign outData    = data_q;
   assign flagZ      = z_q;
   assign flagN      = n_q;
   assign flagC      = c_q;
   assign flagV      = v_q;
   assign errIllegal = err_q;

   always_comb begin
      ext     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op)
         OP_ADD: begin
            ext     = {1'b0, rdDataA} + {1'b0, rdDataB};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = signed_ovf(rdDataA[WIDTH-1], rdDataB[WIDTH-1], ext[WIDTH-1], 1'b0);
         end
         OP_SUB: begin
            ext     = {1'b0, rdDataA} - {1'b0, rdDataB};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = signed_ovf(rdDataA[WIDTH-1], rdDataB[WIDTH-1], ext[WIDTH-1], 1'b1);
         end
         OP_AND: alu_res = rdDataA & rdDataB;
         OP_OR:  alu_res = rdDataA | rdDataB;
         OP_XOR: alu_res = rdDataA ^ rdDataB;
         OP_SHL: alu_res = rdDataA << rdDataB[SHW-1:0];
         OP_SHR: alu_res = rdDataA >> rdDataB[SHW-1:0];
         // Only reaches the result path when no multiplier is built.
         OP_MUL: alu_err = !MUL_ENABLE;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      z_d       = z_q;
      n_d       = n_q;
      c_d       = c_q;
      v_d       = v_q;
      err_d     = err_q;
      mul_start = 1'b0;
      unique case (state_q)
         S_MUL: if (mul_done) begin
            state_d = S_DONE;
            data_d  = mul_prod[WIDTH-1:0];
            z_d     = (mul_prod[WIDTH-1:0] == '0);
            n_d     = mul_prod[WIDTH-1];
            c_d     = |mul_prod[2*WIDTH-1:WIDTH];
            v_d     = 1'b0;
         end
         S_DONE: if (outReady) state_d = S_IDLE;
         default: ;
      endcase
      if (accept) begin
         err_d = alu_err;
         if ((op == OP_MUL) && MUL_ENABLE) begin
            state_d   = S_MUL;
            mul_start = 1'b1;
         end else begin
            state_d = S_DONE;
            data_d  = alu_res;
            z_d     = (alu_res == '0);
            n_d     = alu_res[WIDTH-1];
            c_d     = alu_c;
            v_d     = alu_v;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         z_q     <= z_d;
         n_q     <= n_d;
         c_q     <= c_d;
         v_q     <= v_d;
         err_q   <= err_d;
      end
   end

   generate
      if (MUL_ENABLE) begin : g_mul
         seq_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rstN    (rstN),
            .start   (mul_start),
            .a       (rdDataA),
            .b       (rdDataB),
            .done    (mul_done),
            .product (mul_prod)
         );
      end else begin : g_no_mul
         logic unused_mul_start;
         assign unused_mul_start = mul_start;
         assign mul_done         = 1'b0;
         assign mul_prod         = '0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// tb_seq_alu: drives a multiplier-equipped and a multiplier-less seq_alu with shared stimulus
// and checks both against an arithmetic reference model every cycle. Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_seq_alu;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic z, n, c, v, e;
   } res_t;

   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         inValid = 1'b0;
   logic         outReady = 1'b1;
   logic [W-1:0] rdDataA = '0;
   logic [W-1:0] rdDataB = '0;
   logic [2:0]   opSelect = '0;
   logic         rdy [2];
   logic         vld [2];
   logic [W-1:0] dat [2];
   logic         fz [2], fn [2], fc [2], fv [2], err [2];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   bit   m_valid [2] = '{1'b0, 1'b0};
   int   m_busy  [2] = '{0, 0};
   res_t m_out   [2] = '{'0, '0};
   res_t m_pend  [2] = '{'0, '0};

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W), .MUL_ENABLE(1'b1)) u_dut_mul (
      .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(rdy[0]),
      .rdDataA(rdDataA), .rdDataB(rdDataB), .opSelect(opSelect),
      .outValid(vld[0]), .outReady(outReady), .outData(dat[0]),
      .flagZ(fz[0]), .flagN(fn[0]), .flagC(fc[0]), .flagV(fv[0]), .errIllegal(err[0])
   );

   seq_alu #(.WIDTH(W), .MUL_ENABLE(1'b0)) u_dut_nomul (
      .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(rdy[1]),
      .rdDataA(rdDataA), .rdDataB(rdDataB), .opSelect(opSelect),
      .outValid(vld[1]), .outReady(outReady), .outData(dat[1]),
      .flagZ(fz[1]), .flagN(fn[1]), .flagC(fc[1]), .flagV(fv[1]), .errIllegal(err[1])
   );

   function automatic int sgn(input int unsigned x);
      return (x >= 32768) ? int'(x) - 65536 : int'(x);
   endfunction

   function automatic res_t ref_op(input int op, input int unsigned a, input int unsigned b,
                                   input bit mul_en);
      res_t r;
      longint s;
      longint unsigned p;
      int sr;
      r = '0;
      case (op)
         0: begin
            s = longint'(a) + longint'(b);
            r.d = W'(s);
            r.c = (s > 65535);
            sr = sgn(a) + sgn(b);
            r.v = (sr > 32767) || (sr < -32768);
         end
         1: begin
            s = longint'(a) - longint'(b);
            r.d = W'(s);
            r.c = (a < b);
            sr = sgn(a) - sgn(b);
            r.v = (sr > 32767) || (sr < -32768);
         end
         2: r.d = W'(a & b);
         3: r.d = W'(a | b);
         4: r.d = W'(a ^ b);
         5: r.d = W'(a << (b % 16));
         6: r.d = W'(a >> (b % 16));
         default: begin
            if (mul_en) begin
               p = longint'(a) * longint'(b);
               r.d = W'(p);
               r.c = ((p >> 16) != 0);
            end else begin
               r.e = 1'b1;
            end
         end
      endcase
      r.z = (r.d == 0);
      r.n = r.d[W-1];
      return r;
   endfunction

   function automatic bit exp_ready(input int i);
      return (!m_valid[i] && m_busy[i] == 0) || (m_valid[i] && outReady);
   endfunction

   function automatic logic [4:0] flg(input int i);
      return {fz[i], fn[i], fc[i], fv[i], err[i]};
   endfunction

   function automatic res_t dut_res(input int i);
      return {dat[i], flg(i)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference model: tracks acceptance, multiply latency and held results per DUT.
   initial begin
      forever begin
         @(posedge clk or negedge rstN);
         if (!rstN) begin
            for (int i = 0; i < 2; i++) begin
               m_valid[i] = 1'b0;
               m_busy[i]  = 0;
               m_out[i]   = '0;
            end
         end else begin
            for (int i = 0; i < 2; i++) begin
               bit acc;
               acc = inValid && exp_ready(i);
               if (m_busy[i] > 0) begin
                  m_busy[i]--;
                  if (m_busy[i] == 0) begin
                     m_out[i]   = m_pend[i];
                     m_valid[i] = 1'b1;
                  end
               end else if (m_valid[i] && outReady && !acc) begin
                  m_valid[i] = 1'b0;
               end
               if (acc) begin
                  if (opSelect == 3'd7 && i == 0) begin
                     m_pend[i]  = ref_op(7, rdDataA, rdDataB, 1'b1);
                     m_busy[i]  = W;
                     m_valid[i] = 1'b0;
                  end else begin
                     m_out[i]   = ref_op(int'(opSelect), rdDataA, rdDataB, i == 0);
                     m_valid[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rstN && chk_en) begin
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("inReady dut%0d", i), 32'(rdy[i]), 32'(exp_ready(i)));
               chk($sformatf("outValid dut%0d", i), 32'(vld[i]), 32'(m_valid[i]));
               if (m_valid[i]) chk($sformatf("result dut%0d", i), 32'(dut_res(i)), 32'(m_out[i]));
            end
         end
      end
   end

   task automatic issue(input int op, input int unsigned a, input int unsigned b);
      inValid  = 1'b1;
      opSelect = 3'(op);
      rdDataA  = W'(a);
      rdDataB  = W'(b);
      @(posedge clk);
      #1;
      inValid  = 1'b0;
   endtask

   function automatic int unsigned rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000;
         1: return 32'hFFFF;
         2: return 32'h7FFF;
         3: return 32'h8000;
         default: return $urandom_range(0, 16'hFFFF);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int unsigned t_op [4] = '{0, 1, 3, 6};
      int unsigned t_a  [4] = '{1, 100, 32'h00F0, 32'h8000};
      int unsigned t_b  [4] = '{1, 1, 32'h000F, 4};
      int unsigned t_r  [4] = '{2, 99, 32'h00FF, 32'h0800};

      // Model self-checks against hand-computed values.
      chk("ref add", 32'(ref_op(0, 35, 5, 1'b1)), 32'({16'd40, 5'b00000}));
      chk("ref sub neg", 32'(ref_op(1, 5, 10, 1'b1)), 32'({16'hFFFB, 5'b01100}));
      chk("ref add ovf", 32'(ref_op(0, 16'h7FFF, 1, 1'b1)), 32'({16'h8000, 5'b01010}));
      chk("ref mul", 32'(ref_op(7, 300, 300, 1'b1)), 32'({16'h5F90, 5'b00100}));
      chk("ref mul off", 32'(ref_op(7, 3, 3, 1'b0)), 32'({16'h0000, 5'b10001}));

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset outValid dut%0d", i), 32'(vld[i]), 0);
         chk($sformatf("reset outData dut%0d", i), 32'(dat[i]), 0);
         chk($sformatf("reset flags dut%0d", i), 32'(flg(i)), 0);
      end
      #1 rstN = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("ready after reset", 32'(rdy[0]), 1);

      issue(0, 35, 5);       @(negedge clk); chk("add 35+5", 32'(dut_res(0)), 32'({16'd40, 5'b00000}));
      issue(1, 35, 23);      @(negedge clk); chk("sub 35-23", 32'(dat[0]), 12);
      issue(1, 5, 10);       @(negedge clk); chk("sub 5-10", 32'(dut_res(0)), 32'({16'hFFFB, 5'b01100}));
      issue(0, 'h7FFF, 1);   @(negedge clk); chk("add ovf", 32'(dut_res(0)), 32'({16'h8000, 5'b01010}));
      issue(2, 'hF0F0, 'h0FF0); @(negedge clk); chk("and", 32'(dat[0]), 32'h00F0);
      issue(5, 1, 15);       @(negedge clk); chk("shl 15", 32'(dat[0]), 32'h8000);

      issue(7, 300, 300);
      lat = 0;
      @(negedge clk);
      while (!vld[0] && lat < 40) begin
         chk("mul busy inReady", 32'(rdy[0]), 0);
         @(negedge clk);
         lat++;
      end
      chk("mul latency", 32'(lat), 16);
      chk("mul 300*300", 32'(dut_res(0)), 32'({16'h5F90, 5'b00100}));

      issue(4, 'hAAAA, 'h0F0F);
      outReady = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall data", 32'(dat[0]), 32'hA5A5);
         chk("stall inReady", 32'(rdy[0]), 0);
      end
      outReady = 1'b1;
      for (int j = 0; j < 4; j++) begin
         inValid  = 1'b1;
         opSelect = 3'(t_op[j]);
         rdDataA  = W'(t_a[j]);
         rdDataB  = W'(t_b[j]);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("burst %0d", j), 32'({vld[0], dat[0]}), 32'({1'b1, W'(t_r[j])}));
      end
      inValid = 1'b0;

      issue(7, 1234, 77);
      repeat (5) @(posedge clk);
      #2 rstN = 1'b0;
      #1 chk("reset mid-mul outValid", 32'(vld[0]), 0);
      @(posedge clk);
      #1 rstN = 1'b1;
      repeat (20) @(negedge clk);
      chk("no partial result", 32'(vld[0]), 0);
      issue(0, 2, 2);        @(negedge clk); chk("add 2+2", 32'(dat[0]), 4);

      issue(7, 3, 3);        @(negedge clk); chk("illegal mul", 32'(dut_res(1)), 32'({16'h0000, 5'b10001}));
      issue(3, 5, 2);        @(negedge clk); chk("or after illegal", 32'(dut_res(1)), 32'({16'h0007, 5'b00000}));
      repeat (20) @(negedge clk);

      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         inValid  = ($urandom_range(0, 3) != 0);
         outReady = ($urandom_range(0, 3) != 0);
         opSelect = 3'($urandom_range(0, 7));
         rdDataA  = W'(rnd_val());
         rdDataB  = W'(rnd_val());
         if (k == 1500) begin
            #2 rstN = 1'b0;
            @(posedge clk);
            #1 rstN = 1'b1;
         end
      end
      inValid = 1'b0;
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
